router_fsm: RTL and testbench
=============================

// Module: router_fsm
// PURPOSE
//  Packet-sequencing controller for the 1x3 router input side. Decodes the header address
//  byte and sequences the header/payload/parity loads into the input register and the
//  destination FIFO. Drives router_sync (detect_add, write_enb_reg) and the register stage
//  (lfd/ld/laf/full/rst_int). Reacts to FIFO full/empty state and to per-port soft resets.
// PARAMETERS
//  WAIT_LIMIT  63  cycles allowed in WAIT_TILL_EMPTY before drop (ROUTER_FSM_WAIT_TIMEOUT_EN only)
//  CNT_W       6   width of wait counter; WAIT_LIMIT must fit in CNT_W bits
// PORTS
//  clock          in   1  single clock; all state updates on rising edge
//  resetn         in   1  synchronous, active-low reset
//  pkt_valid      in   1  source packet valid; header byte present when high in DECODE_ADDRESS
//  data_in        in   2  header address bits [1:0]; 0/1/2 = port, 3 = invalid
//  fifo_full      in   1  full flag of the currently addressed FIFO (from router_sync)
//  fifo_empty_0/1/2 in 1  per-FIFO empty flags
//  soft_reset_0/1/2 in 1  per-port soft reset (from router_sync)
//  parity_done    in   1  register stage has captured the parity byte
//  low_pkt_valid  in   1  register stage holds the last payload byte after pkt_valid fell
//  detect_add     out  1  state == DECODE_ADDRESS
//  lfd_state      out  1  state == LOAD_FIRST_DATA
//  ld_state       out  1  state == LOAD_DATA
//  laf_state      out  1  state == LOAD_AFTER_FULL
//  full_state     out  1  state == FIFO_FULL_STATE
//  write_enb_reg  out  1  state in {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL}
//  rst_int_reg    out  1  state == CHECK_PARITY_ERROR
//  busy           out  1  high in every state except DECODE_ADDRESS and LOAD_DATA
//  drop_pkt       out  1  one-cycle pulse on wait timeout (0 when macro absent)
// BEHAVIOUR
//  Moore machine, 8 states, 3-bit one-hot-free binary encoding; outputs decoded from state only.
//  Reset (resetn=0 at edge): state=DECODE_ADDRESS, addr_q=0, wait_cnt=0; outputs after reset:
//   detect_add=1, all others 0 (busy=0, drop_pkt=0).
//  addr_q: captures data_in on the edge leaving DECODE_ADDRESS with pkt_valid=1 and data_in!=3.
//  Transitions (priority top-down):
//   1. resetn=0 -> DECODE_ADDRESS.
//   2. state!=DECODE_ADDRESS and soft_reset_<addr_q>=1 -> DECODE_ADDRESS (other ports' soft resets ignored).
//   DECODE_ADDRESS: pkt_valid & data_in<3 & fifo_empty_<data_in> -> LOAD_FIRST_DATA;
//     pkt_valid & data_in<3 & !fifo_empty_<data_in> -> WAIT_TILL_EMPTY; data_in==3 or !pkt_valid -> stay.
//   WAIT_TILL_EMPTY: fifo_empty_<addr_q> -> LOAD_FIRST_DATA; else stay.
//   LOAD_FIRST_DATA: -> LOAD_DATA unconditionally (1 cycle).
//   LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
//   FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
//   LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
//   LOAD_PARITY: -> CHECK_PARITY_ERROR unconditionally.
//   CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
//  Latency: header accepted in DECODE_ADDRESS with empty FIFO -> lfd_state high next cycle,
//   ld_state the cycle after. Minimum packet (header+1 payload+parity) back to detect_add: 5 cycles.
//  fifo_full and pkt_valid both falling in LOAD_DATA: full has priority (go FIFO_FULL_STATE).
//  Illegal state encodings -> DECODE_ADDRESS next cycle.
// CONFIGURATION
//  ROUTER_FSM_WAIT_TIMEOUT_EN defined: wait_cnt clears on entry to WAIT_TILL_EMPTY, increments each
//   cycle there; when wait_cnt==WAIT_LIMIT and FIFO still not empty -> DECODE_ADDRESS and
//   drop_pkt=1 for that one transition cycle. Empty on the limit cycle wins (go LOAD_FIRST_DATA).
//  Not defined: no counter, WAIT_TILL_EMPTY waits indefinitely, drop_pkt tied 0.
// TESTING
//  T1 reset: resetn=0 one edge mid-LOAD_DATA -> detect_add=1, busy=0, write_enb_reg=0 next cycle.
//  T2 basic: pkt_valid=1,data_in=1,fifo_empty_1=1, 3 payload, pkt_valid=0 -> DA,LFD,LD x3,LP,CPE,DA;
//     write_enb_reg high 4 cycles, rst_int_reg pulse 1 cycle.
//  T3 full: fifo_full=1 during LD for 4 cycles -> full_state=1,busy=1 4 cycles, then laf_state 1
//     cycle, low_pkt_valid=1 -> LOAD_PARITY.
//  T4 wait: data_in=2,fifo_empty_2=0 for 10 cycles -> busy=1 10 cycles, lfd_state 1 cycle after empty.
//  T5 soft reset: addr_q=0 in LD, soft_reset_1=1 -> no effect; soft_reset_0=1 -> detect_add next cycle.
//  T6 macro on, WAIT_LIMIT=63, fifo_empty_0 held 0 -> drop_pkt pulse after 64 cycles; data_in=3 never leaves DA.

Source files
------------

// File: rtl/router_fsm_if.sv
// Control bundle between the router input-side sequencer and its neighbours
// (router_sync, register stage, source). The sequencer is the master side.
interface router_fsm_if;
    // Toward the sequencer
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    // From the sequencer
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;
    logic       drop_pkt;

    modport master (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
        output write_enb_reg, rst_int_reg, busy, drop_pkt
    );

    modport slave (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
        input  write_enb_reg, rst_int_reg, busy, drop_pkt
    );
endinterface

// File: rtl/router_fsm.sv
// Router input-side packet sequencer. Decodes the header address, then walks the
// header / payload / parity loads into the register stage and destination FIFO.
// Moore machine: every output is a registered decode of the state.
// Optional feature: define ROUTER_FSM_WAIT_TIMEOUT_EN to bound the time spent in
// WAIT_TILL_EMPTY to WAIT_LIMIT+1 cycles, after which the packet is dropped.
module router_fsm #(
    parameter int unsigned WAIT_LIMIT = 63,
    parameter int unsigned CNT_W      = 6
) (
    input logic         clock,
    input logic         resetn,
    router_fsm_if.master bus
);

    if (WAIT_LIMIT >= (1 << CNT_W)) begin : g_limit_check
        $error("WAIT_LIMIT does not fit in CNT_W bits");
    end

    typedef enum logic [2:0] {
        StDecodeAddress    = 3'd0,
        StWaitTillEmpty    = 3'd1,
        StLoadFirstData    = 3'd2,
        StLoadData         = 3'd3,
        StFifoFullState    = 3'd4,
        StLoadAfterFull    = 3'd5,
        StLoadParity       = 3'd6,
        StCheckParityError = 3'd7
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] addr_q;
    logic       drop_d;
    logic       hdr_empty;   // empty flag of the port named by the incoming header
    logic       addr_empty;  // empty flag of the latched destination port
    logic       addr_soft_reset;

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt_q;
`endif

    // Per-port flag selection by header byte and by latched address
    always_comb begin
        hdr_empty       = 1'b0;
        addr_empty      = 1'b0;
        addr_soft_reset = 1'b0;
        case (bus.data_in)
            2'd0:    hdr_empty = bus.fifo_empty_0;
            2'd1:    hdr_empty = bus.fifo_empty_1;
            2'd2:    hdr_empty = bus.fifo_empty_2;
            default: hdr_empty = 1'b0;
        endcase
        case (addr_q)
            2'd0: begin
                addr_empty      = bus.fifo_empty_0;
                addr_soft_reset = bus.soft_reset_0;
            end
            2'd1: begin
                addr_empty      = bus.fifo_empty_1;
                addr_soft_reset = bus.soft_reset_1;
            end
            2'd2: begin
                addr_empty      = bus.fifo_empty_2;
                addr_soft_reset = bus.soft_reset_2;
            end
            default: begin
                addr_empty      = 1'b0;
                addr_soft_reset = 1'b0;
            end
        endcase
    end

    // Next-state logic; soft reset of the active port overrides every state but decode
    always_comb begin
        state_d = state_q;
        drop_d  = 1'b0;
        case (state_q)
            StDecodeAddress: begin
                if (bus.pkt_valid && bus.data_in != 2'd3) begin
                    state_d = hdr_empty ? StLoadFirstData : StWaitTillEmpty;
                end
            end
            StWaitTillEmpty: begin
                if (addr_empty) begin
                    state_d = StLoadFirstData;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
                end else if (wait_cnt_q == CNT_W'(WAIT_LIMIT)) begin
                    state_d = StDecodeAddress;
                    drop_d  = 1'b1;
`endif
                end
            end
            StLoadFirstData: state_d = StLoadData;
            StLoadData: begin
                // full wins over end-of-packet
                if (bus.fifo_full) begin
                    state_d = StFifoFullState;
                end else if (!bus.pkt_valid) begin
                    state_d = StLoadParity;
                end
            end
            StFifoFullState: begin
                if (!bus.fifo_full) begin
                    state_d = StLoadAfterFull;
                end
            end
            StLoadAfterFull: begin
                if (bus.parity_done) begin
                    state_d = StDecodeAddress;
                end else if (bus.low_pkt_valid) begin
                    state_d = StLoadParity;
                end else begin
                    state_d = StLoadData;
                end
            end
            StLoadParity: state_d = StCheckParityError;
            StCheckParityError: begin
                state_d = bus.fifo_full ? StFifoFullState : StDecodeAddress;
            end
            default: state_d = StDecodeAddress;
        endcase

        if (state_q != StDecodeAddress && addr_soft_reset) begin
            state_d = StDecodeAddress;
            drop_d  = 1'b0;
        end
    end

    // State, address latch and registered output decode
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q           <= StDecodeAddress;
            addr_q            <= 2'd0;
            bus.detect_add    <= 1'b1;
            bus.lfd_state     <= 1'b0;
            bus.ld_state      <= 1'b0;
            bus.laf_state     <= 1'b0;
            bus.full_state    <= 1'b0;
            bus.write_enb_reg <= 1'b0;
            bus.rst_int_reg   <= 1'b0;
            bus.busy          <= 1'b0;
            bus.drop_pkt      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecodeAddress && bus.pkt_valid && bus.data_in != 2'd3) begin
                addr_q <= bus.data_in;
            end
            // Decoding state_d keeps the outputs aligned with state_q
            bus.detect_add    <= (state_d == StDecodeAddress);
            bus.lfd_state     <= (state_d == StLoadFirstData);
            bus.ld_state      <= (state_d == StLoadData);
            bus.laf_state     <= (state_d == StLoadAfterFull);
            bus.full_state    <= (state_d == StFifoFullState);
            bus.write_enb_reg <= (state_d == StLoadData) || (state_d == StLoadParity) ||
                                 (state_d == StLoadAfterFull);
            bus.rst_int_reg   <= (state_d == StCheckParityError);
            bus.busy          <= (state_d != StDecodeAddress) && (state_d != StLoadData);
            bus.drop_pkt      <= drop_d;
        end
    end

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    // Cycles spent in WAIT_TILL_EMPTY; cleared on entry
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wait_cnt_q <= '0;
        end else if (state_q != StWaitTillEmpty) begin
            wait_cnt_q <= '0;
        end else if (wait_cnt_q != CNT_W'(WAIT_LIMIT)) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: each step drives inputs, queues the expected
// output vector, and compares it one clock edge later.
module tb_router_fsm;

    // {detect_add, lfd, ld, laf, full, write_enb_reg, rst_int_reg, busy, drop_pkt}
    localparam logic [8:0] V_DA   = 9'b100000000;
    localparam logic [8:0] V_WTE  = 9'b000000010;
    localparam logic [8:0] V_LFD  = 9'b010000010;
    localparam logic [8:0] V_LD   = 9'b001001000;
    localparam logic [8:0] V_FFS  = 9'b000010010;
    localparam logic [8:0] V_LAF  = 9'b000101010;
    localparam logic [8:0] V_LP   = 9'b000001010;
    localparam logic [8:0] V_CPE  = 9'b000000110;
    localparam logic [8:0] V_DROP = 9'b100000001;

    typedef struct packed {
        logic       rstn;
        logic       pv;
        logic [1:0] din;
        logic       full;
        logic [2:0] emp;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        logic [8:0] exp;
    } stim_t;

    logic clock = 1'b0;
    logic resetn;
    int   vectors = 0;
    int   miscompares = 0;
    logic [8:0] exp_q[$];
    logic [8:0] outs;

    router_fsm_if bus_if ();

    router_fsm #(
        .WAIT_LIMIT(63),
        .CNT_W     (6)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    assign outs = {bus_if.detect_add, bus_if.lfd_state, bus_if.ld_state, bus_if.laf_state,
                   bus_if.full_state, bus_if.write_enb_reg, bus_if.rst_int_reg, bus_if.busy,
                   bus_if.drop_pkt};

    function automatic stim_t mk(input logic rstn, input logic pv, input logic [1:0] din,
                                 input logic full, input logic [2:0] emp,
                                 input logic [2:0] sr, input logic pd, input logic lpv,
                                 input logic [8:0] exp);
        stim_t s;
        s.rstn = rstn; s.pv = pv; s.din = din; s.full = full; s.emp = emp;
        s.sr = sr; s.pd = pd; s.lpv = lpv; s.exp = exp;
        return s;
    endfunction

    // Apply one cycle of stimulus and queue the state expected after the next edge
    task automatic drive(input stim_t s);
        resetn               = s.rstn;
        bus_if.pkt_valid     = s.pv;
        bus_if.data_in       = s.din;
        bus_if.fifo_full     = s.full;
        bus_if.fifo_empty_0  = s.emp[0];
        bus_if.fifo_empty_1  = s.emp[1];
        bus_if.fifo_empty_2  = s.emp[2];
        bus_if.soft_reset_0  = s.sr[0];
        bus_if.soft_reset_1  = s.sr[1];
        bus_if.soft_reset_2  = s.sr[2];
        bus_if.parity_done   = s.pd;
        bus_if.low_pkt_valid = s.lpv;
        exp_q.push_back(s.exp);
    endtask

    task automatic test_reset();
        stim_t seq[$];
        logic [8:0] want;
        seq.push_back(mk(0, 1, 0, 0, 3'b111, 0, 0, 0, V_DA));  // reset beats a header
        seq.push_back(mk(1, 0, 0, 0, 3'b111, 0, 0, 0, V_DA));
        seq.push_back(mk(1, 1, 0, 0, 3'b111, 0, 0, 0, V_LFD));
        seq.push_back(mk(1, 1, 0, 0, 3'b111, 0, 0, 0, V_LD));
        seq.push_back(mk(0, 1, 0, 0, 3'b111, 0, 0, 0, V_DA));  // reset mid-LOAD_DATA
        seq.push_back(mk(1, 0, 0, 0, 3'b111, 0, 0, 0, V_DA));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clock); #1;
            want = exp_q.pop_front();
            vectors++;
            if (outs !== want) begin
                miscompares++;
                $display("FAIL reset step %0d: got %b expected %b", i, outs, want);
            end
        end
    endtask

    task automatic test_basic();
        stim_t seq[$];
        logic [8:0] want;
        seq.push_back(mk(1, 1, 1, 0, 3'b010, 0, 0, 0, V_LFD));
        seq.push_back(mk(1, 1, 1, 0, 3'b010, 0, 0, 0, V_LD));
        seq.push_back(mk(1, 1, 1, 0, 3'b010, 0, 0, 0, V_LD));
        seq.push_back(mk(1, 1, 1, 0, 3'b010, 0, 0, 0, V_LD));
        seq.push_back(mk(1, 0, 1, 0, 3'b010, 0, 0, 0, V_LP));
        seq.push_back(mk(1, 0, 1, 0, 3'b010, 0, 0, 0, V_CPE));
        seq.push_back(mk(1, 0, 1, 0, 3'b010, 0, 0, 0, V_DA));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clock); #1;
            want = exp_q.pop_front();
            vectors++;
            if (outs !== want) begin
                miscompares++;
                $display("FAIL basic step %0d: got %b expected %b", i, outs, want);
            end
        end
    endtask

    task automatic test_full();
        stim_t seq[$];
        logic [8:0] want;
        seq.push_back(mk(1, 1, 0, 0, 3'b111, 0, 0, 0, V_LFD));
        seq.push_back(mk(1, 1, 0, 0, 3'b111, 0, 0, 0, V_LD));
        for (int k = 0; k < 4; k++) seq.push_back(mk(1, 1, 0, 1, 3'b111, 0, 0, 0, V_FFS));
        seq.push_back(mk(1, 0, 0, 0, 3'b111, 0, 0, 0, V_LAF));
        seq.push_back(mk(1, 0, 0, 0, 3'b111, 0, 0, 1, V_LP));   // low_pkt_valid
        seq.push_back(mk(1, 0, 0, 1, 3'b111, 0, 0, 0, V_CPE));  // LP ignores full
        seq.push_back(mk(1, 0, 0, 1, 3'b111, 0, 0, 0, V_FFS));  // CPE with full
        seq.push_back(mk(1, 0, 0, 0, 3'b111, 0, 0, 0, V_LAF));
        seq.push_back(mk(1, 0, 0, 0, 3'b111, 0, 1, 1, V_DA));   // parity_done first
        seq.push_back(mk(1, 1, 0, 0, 3'b111, 0, 0, 0, V_LFD));
        seq.push_back(mk(1, 1, 0, 0, 3'b111, 0, 0, 0, V_LD));
        seq.push_back(mk(1, 0, 0, 1, 3'b111, 0, 0, 0, V_FFS));  // full beats !pkt_valid
        seq.push_back(mk(1, 0, 0, 0, 3'b111, 0, 0, 0, V_LAF));
        seq.push_back(mk(1, 1, 0, 0, 3'b111, 0, 0, 0, V_LD));   // LAF back to LD
        seq.push_back(mk(1, 0, 0, 0, 3'b111, 0, 0, 0, V_LP));
        seq.push_back(mk(1, 0, 0, 0, 3'b111, 0, 0, 0, V_CPE));
        seq.push_back(mk(1, 0, 0, 0, 3'b111, 0, 0, 0, V_DA));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clock); #1;
            want = exp_q.pop_front();
            vectors++;
            if (outs !== want) begin
                miscompares++;
                $display("FAIL full step %0d: got %b expected %b", i, outs, want);
            end
        end
    endtask

    task automatic test_wait();
        stim_t seq[$];
        logic [8:0] want;
        seq.push_back(mk(1, 1, 2, 0, 3'b011, 0, 0, 0, V_WTE));
        for (int k = 0; k < 9; k++) begin
            // header bits now name an empty port; wait must follow the latched port
            seq.push_back(mk(1, 1, 1, 0, 3'b011, 0, 0, 0, V_WTE));
        end
        seq.push_back(mk(1, 1, 2, 0, 3'b111, 0, 0, 0, V_LFD));
        seq.push_back(mk(1, 1, 2, 0, 3'b111, 0, 0, 0, V_LD));
        seq.push_back(mk(1, 0, 2, 0, 3'b111, 0, 0, 0, V_LP));
        seq.push_back(mk(1, 0, 2, 0, 3'b111, 0, 0, 0, V_CPE));
        seq.push_back(mk(1, 0, 2, 0, 3'b111, 0, 0, 0, V_DA));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clock); #1;
            want = exp_q.pop_front();
            vectors++;
            if (outs !== want) begin
                miscompares++;
                $display("FAIL wait step %0d: got %b expected %b", i, outs, want);
            end
        end
    endtask

    task automatic test_soft_reset();
        stim_t seq[$];
        logic [8:0] want;
        seq.push_back(mk(1, 1, 0, 0, 3'b111, 3'b000, 0, 0, V_LFD));
        seq.push_back(mk(1, 1, 0, 0, 3'b111, 3'b000, 0, 0, V_LD));
        seq.push_back(mk(1, 1, 0, 0, 3'b111, 3'b010, 0, 0, V_LD));  // other port ignored
        seq.push_back(mk(1, 1, 0, 0, 3'b111, 3'b100, 0, 0, V_LD));
        seq.push_back(mk(1, 1, 0, 0, 3'b111, 3'b001, 0, 0, V_DA));  // own port
        seq.push_back(mk(1, 0, 0, 0, 3'b111, 3'b001, 0, 0, V_DA));
        seq.push_back(mk(1, 1, 1, 0, 3'b101, 3'b000, 0, 0, V_WTE));
        seq.push_back(mk(1, 1, 1, 0, 3'b101, 3'b001, 0, 0, V_WTE));
        seq.push_back(mk(1, 0, 1, 0, 3'b101, 3'b010, 0, 0, V_DA));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clock); #1;
            want = exp_q.pop_front();
            vectors++;
            if (outs !== want) begin
                miscompares++;
                $display("FAIL soft_reset step %0d: got %b expected %b", i, outs, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t seq[$];
        logic [8:0] want;
        // minimum packet: header, one payload, parity -> detect_add after 5 edges
        seq.push_back(mk(1, 1, 2, 0, 3'b111, 0, 0, 0, V_LFD));
        seq.push_back(mk(1, 0, 2, 0, 3'b111, 0, 0, 0, V_LD));
        seq.push_back(mk(1, 0, 2, 0, 3'b111, 0, 0, 0, V_LP));
        seq.push_back(mk(1, 0, 2, 0, 3'b111, 0, 0, 0, V_CPE));
        seq.push_back(mk(1, 0, 2, 0, 3'b111, 0, 0, 0, V_DA));
        seq.push_back(mk(1, 1, 0, 0, 3'b111, 0, 0, 0, V_LFD));
        seq.push_back(mk(1, 0, 0, 0, 3'b111, 0, 0, 0, V_LD));
        seq.push_back(mk(1, 0, 0, 0, 3'b111, 0, 0, 0, V_LP));
        seq.push_back(mk(1, 0, 0, 0, 3'b111, 0, 0, 0, V_CPE));
        seq.push_back(mk(1, 0, 0, 0, 3'b111, 0, 0, 0, V_DA));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clock); #1;
            want = exp_q.pop_front();
            vectors++;
            if (outs !== want) begin
                miscompares++;
                $display("FAIL back_to_back step %0d: got %b expected %b", i, outs, want);
            end
        end
    endtask

    task automatic test_invalid_and_timeout();
        stim_t seq[$];
        logic [8:0] want;
        for (int k = 0; k < 4; k++) seq.push_back(mk(1, 1, 3, 0, 3'b111, 0, 0, 0, V_DA));
        seq.push_back(mk(1, 1, 0, 0, 3'b110, 0, 0, 0, V_WTE));
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
        for (int k = 0; k < 63; k++) seq.push_back(mk(1, 0, 0, 0, 3'b110, 0, 0, 0, V_WTE));
        seq.push_back(mk(1, 0, 0, 0, 3'b110, 0, 0, 0, V_DROP));
        seq.push_back(mk(1, 0, 0, 0, 3'b110, 0, 0, 0, V_DA));
`else
        for (int k = 0; k < 70; k++) seq.push_back(mk(1, 0, 0, 0, 3'b110, 0, 0, 0, V_WTE));
        seq.push_back(mk(1, 0, 0, 0, 3'b110, 3'b001, 0, 0, V_DA));
`endif
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clock); #1;
            want = exp_q.pop_front();
            vectors++;
            if (outs !== want) begin
                miscompares++;
                $display("FAIL timeout step %0d: got %b expected %b", i, outs, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_wait();
        test_soft_reset();
        test_back_to_back();
        test_invalid_and_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
